// File: rtl/memory_interface.sv
// Bus initiator for the LUMOS multicycle core: word-aligned reads and writes, sub-word stores
// done as read-modify-write, load extension, misalignment detection and a read timeout.
module memory_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request,
  input  logic        requestWrite,
  input  logic [31:0] requestAddress,
  input  logic [1:0]  requestSize,
  input  logic        requestUnsigned,
  input  logic [31:0] requestData,
  output logic        busy,
  output logic        done,
  output logic [31:0] readData,
  output logic        misaligned,
  output logic        busFault,
  inout  wire  [31:0] memoryData,
  output logic [31:0] memoryAddress,
  output logic        memoryReadWrite,
  output logic        memoryEnable,
  input  logic        memoryReady
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  localparam logic BusRead  = 1'b0;
  localparam logic BusWrite = 1'b1;

  typedef enum logic [2:0] {StIdle, StRead, StMerge, StWrite, StDone, StError} state_e;

  state_e         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic           write_q, write_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    word_q, word_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           fault_q, fault_d;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'b11) || (sz == SzHalf && a[0]) || (sz == SzWord && a != 2'b00);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] sz, input logic uns);
    logic [31:0] sh_b, sh_h;
    sh_b = w >> {a, 3'b000};
    sh_h = w >> {a[1], 4'b0000};
    if (sz == SzByte) begin
      return {{24{sh_b[7] & ~uns}}, sh_b[7:0]};
    end else if (sz == SzHalf) begin
      return {{16{sh_h[15] & ~uns}}, sh_h[15:0]};
    end
    return w;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] mask, lane;
    if (sz == SzByte) begin
      mask = 32'h0000_00ff << {a, 3'b000};
      lane = {24'h0, d[7:0]} << {a, 3'b000};
    end else begin
      mask = 32'h0000_ffff << {a[1], 4'b0000};
      lane = {16'h0, d[15:0]} << {a[1], 4'b0000};
    end
    return (w & ~mask) | lane;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        if (request) begin
          addr_d  = requestAddress;
          write_d = requestWrite;
          size_d  = requestSize;
          uns_d   = requestUnsigned;
          wdata_d = requestData;
          word_d  = requestData;
          cnt_d   = '0;
          fault_d = 1'b0;
          if (is_misaligned(requestSize, requestAddress[1:0])) begin
            state_d = StError;
          end else if (requestWrite && requestSize == SzWord) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        // Ready has priority over a timeout that expires in the same cycle.
        if (memoryReady) begin
          if (write_q) begin
            word_d  = memoryData;
            state_d = StMerge;
          end else begin
            rdata_d = load_extract(memoryData, addr_q[1:0], size_q, uns_q);
            state_d = StDone;
          end
        end else if (cnt_q == CntLast) begin
          fault_d = 1'b1;
          state_d = StError;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StMerge: begin
        word_d  = store_merge(word_q, wdata_q, addr_q[1:0], size_q);
        state_d = StWrite;
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy            = (state_q != StIdle);
    done            = (state_q == StDone);
    misaligned      = (state_q == StError) && !fault_q;
    busFault        = (state_q == StError) && fault_q;
    memoryEnable    = (state_q == StRead) || (state_q == StWrite);
    memoryReadWrite = (state_q == StWrite) ? BusWrite : BusRead;
    memoryAddress   = {addr_q[31:2], 2'b00};
    readData        = rdata_q;
  end

  assign memoryData = (state_q == StWrite) ? word_q : 32'hzzzz_zzzz;

endmodule

// File: doc/memory_interface.md
Name: memory_interface

Overview:
- Synthesizable bus initiator that connects the LUMOS multicycle control unit to the shared memory bus (memoryData, memoryAddress, memoryReadWrite, memoryEnable, memoryReady).
- Converts fetch, load and store requests of byte, half or word size into word-aligned bus transactions.
- Sub-word stores are done as read-modify-write, because the bus has no byte enables.
- Performs load extraction with sign or zero extension, detects misalignment, and times out stalled reads.

Parameters:
- TIMEOUT_CYCLES, 255: READ-state cycles without memoryReady before a bus fault is raised.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- request  input  1  start transaction; sampled only in IDLE
- requestWrite  input  1  1 = store, 0 = load/fetch
- requestAddress  input  32  byte address
- requestSize  input  2  00 byte, 01 half, 10 word, 11 illegal
- requestUnsigned  input  1  zero-extend loads when 1
- requestData  input  32  store data, right-aligned
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle completion pulse
- readData  output  32  extended load result; valid while done=1 and held until next done
- misaligned  output  1  one-cycle pulse on misaligned or illegal-size request
- busFault  output  1  one-cycle pulse on read timeout
- memoryData  inout  32  bus data; driven only in WRITE state, otherwise high-Z
- memoryAddress  output  32  {requestAddress[31:2],2'b00} during a transaction
- memoryReadWrite  output  1  `READ (0) / `WRITE (1)
- memoryEnable  output  1  transaction active
- memoryReady  input  1  responder read-data-valid

Behaviour:
- Reset (asynchronous): state=IDLE; busy, done, misaligned, busFault, memoryEnable = 0; memoryReadWrite=`READ; memoryAddress=0; readData=0; memoryData high-Z. Asserting reset mid-transaction releases the bus immediately and abandons the transaction with no done pulse.
- States: IDLE, READ, MERGE, WRITE, DONE, ERROR.
- IDLE, on request=1: latch all request fields.
  - Half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> ERROR. No bus activity.
  - Store word -> WRITE.
  - Any other request (load, or store byte/half) -> READ.
- READ: memoryEnable=1, memoryReadWrite=`READ.
  - Timeout counter starts at 0 on READ entry and increments each cycle.
  - At a posedge with memoryReady=1: capture memoryData. Load -> DONE; store -> MERGE.
  - Counter reaching TIMEOUT_CYCLES -> ERROR with busFault.
- MERGE: memoryEnable=0 for one bus-turnaround cycle.
  - Replace lane addr[1:0]*8 (byte) or addr[1]*16 (half) of the captured word with the low bits of requestData.
  - Next state WRITE.
- WRITE: memoryEnable=1, memoryReadWrite=`WRITE, memoryData driven, for exactly one cycle (the responder commits at that posedge; no ready is expected). Next state DONE.
- DONE: memoryEnable=0, done=1 for one cycle, then IDLE.
  - For loads, readData = selected lane, sign-extended unless requestUnsigned; a word load is passed through unchanged.
- ERROR: memoryEnable=0, misaligned or busFault=1 for one cycle, then IDLE. readData unchanged.
- memoryEnable is always low for at least one cycle between consecutive transactions (DONE/ERROR, then IDLE).
- request while busy=1 is ignored; the requester must hold request until it sees busy. request in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.
- If memoryReady rises in the same cycle the counter hits TIMEOUT_CYCLES, ready wins: the transaction completes with no fault.
- Latency: word store = request cycle + 2 (WRITE, DONE). Load with ready first seen N cycles after READ entry = N+2 cycles. Sub-word store = load latency + 2.

Test Plan:
- Load word at 0x0000_0010, memory[4]=0xDEADBEEF, ready after 4 cycles -> single READ at 0x10, done with readData=0xDEADBEEF, no write cycle.
- Load byte signed at 0x13 with word 0x80FF_0011 -> readData=0xFFFF_FF80; same request unsigned -> 0x0000_0080.
- Store half 0xABCD to 0x22, memory[8]=0x1122_3344 -> READ, one cycle enable low, WRITE of 0xABCD_3344, done; memory[8]=0xABCD3344.
- Store word 0x12345678 to 0x30 -> exactly one enable-high WRITE cycle with no READ, done two cycles after request.
- Load word at 0x06 -> misaligned pulse, memoryEnable never asserts; size=11 at 0x00 -> misaligned.
- With TIMEOUT_CYCLES=8 and ready never asserted -> busFault after 8 READ cycles, then IDLE. Separately, asserting reset during READ -> memoryEnable drops asynchronously and no done pulse follows.
